// File: rtl/dma_ring_engine.sv
// rtl/dma_ring_engine.sv - ring-to-ring DMA copy engine through an external show-ahead FIFO
module dma_ring_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_BEATS = 8,
  parameter int RING_BYTES  = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           reg_wr_data,
  input  logic [5:0]            reg_wr_en,
  output logic [31:0]           src_base,
  output logic [31:0]           dest_base,
  output logic [31:0]           tail_ptr,
  output logic [31:0]           head_ptr,
  output logic [31:0]           dma_size,
  output logic [31:0]           ctrl_stat,
  output logic                  intr,
  output logic [31:0]           rd_req_addr,
  output logic [7:0]            rd_req_len,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  input  logic                  rd_valid,
  input  logic                  rd_last,
  output logic                  rd_ready,
  output logic [31:0]           wr_req_addr,
  output logic [7:0]            wr_req_len,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_valid,
  output logic                  wr_last,
  input  logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_wen,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_is_empty,
  input  logic                  fifo_is_full
);

  localparam int          BB        = DATA_WIDTH / 8;
  localparam int          LBB       = $clog2(BB);
  localparam logic [31:0] RING_MASK = 32'(RING_BYTES - 1);
  localparam logic [31:0] MAX_BEATS = 32'(BURST_BEATS);

  typedef enum logic [2:0] {IDLE, RREQ, RDAT, WREQ, WDAT} state_t;
  state_t state, state_nxt;

  logic [31:0] s_l, d_l, t_l, off, rem;
  logic [7:0]  cnt;
  logic [31:0] n, n_bytes, ring_off, ctrl_set;
  logic        start, last_beat, final_done, err_set;

  assign start      = ctrl_stat[0] && (head_ptr != tail_ptr) && (dma_size[31:LBB] != '0);
  assign n          = (rem > MAX_BEATS) ? MAX_BEATS : rem;
  assign n_bytes    = n << LBB;
  assign ring_off   = (t_l + off) & RING_MASK;
  assign last_beat  = fifo_rden && (cnt == n[7:0] - 8'd1);
  assign final_done = last_beat && (rem == n);
  assign err_set    = (fifo_wen && fifo_is_full) || (fifo_rden && fifo_is_empty);
  assign ctrl_set   = {final_done, err_set, 30'h0};
  assign intr       = ctrl_stat[31] & ctrl_stat[1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RREQ;
      RREQ:    if (rd_req_ready) state_nxt = RDAT;
      RDAT:    if (fifo_wen && rd_last) state_nxt = WREQ;
      WREQ:    if (wr_req_ready) state_nxt = WDAT;
      WDAT:    if (last_beat) state_nxt = final_done ? IDLE : RREQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_req_valid = (state == RREQ);
    wr_req_valid = (state == WREQ);
    rd_req_addr  = s_l + ring_off;
    wr_req_addr  = d_l + ring_off;
    rd_req_len   = (state == IDLE) ? 8'h0 : n[7:0] - 8'd1;
    wr_req_len   = rd_req_len;
    rd_ready     = (state == RDAT) && !fifo_is_full;
    fifo_wen     = rd_valid && rd_ready;
    fifo_wdata   = (state == RDAT) ? rd_rdata : '0;
    wr_valid     = (state == WDAT) && !fifo_is_empty;
    wr_data      = (state == WDAT) ? fifo_rdata : '0;
    fifo_rden    = wr_valid && wr_ready;
    wr_last      = wr_valid && (cnt == n[7:0] - 8'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_base  <= '0;
      dest_base <= '0;
      tail_ptr  <= '0;
      head_ptr  <= '0;
      dma_size  <= '0;
      ctrl_stat <= '0;
      s_l       <= '0;
      d_l       <= '0;
      t_l       <= '0;
      off       <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      // Working copies isolate the running sub-buffer from CPU register writes.
      if (state == IDLE && start) begin
        s_l <= src_base;
        d_l <= dest_base;
        t_l <= tail_ptr;
        off <= '0;
        rem <= dma_size >> LBB;
        cnt <= '0;
      end
      if (fifo_rden) begin
        if (last_beat) begin
          cnt <= '0;
          off <= off + n_bytes;
          rem <= rem - n;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
      // off + n_bytes on the final burst equals the whole sub-buffer length.
      if (final_done) tail_ptr <= (t_l + off + n_bytes) & RING_MASK;
      case (reg_wr_en)
        6'b000001: src_base  <= reg_wr_data;
        6'b000010: dest_base <= reg_wr_data;
        6'b000100: tail_ptr  <= reg_wr_data;
        6'b001000: head_ptr  <= reg_wr_data;
        6'b010000: dma_size  <= reg_wr_data;
        default: ;
      endcase
      if (reg_wr_en == 6'b100000) ctrl_stat <= reg_wr_data | ctrl_set;
      else                        ctrl_stat <= ctrl_stat | ctrl_set;
    end
  end

endmodule

// File: tb/tb_dma_ring_engine.sv
// tb/tb_dma_ring_engine.sv - scoreboard bench for dma_ring_engine with memory responder and FIFO model
`timescale 1ns/1ps
module tb_dma_ring_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] reg_wr_data = '0;
  logic [5:0]  reg_wr_en = '0;
  logic [31:0] src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat;
  logic        intr;
  logic [31:0] rd_req_addr, wr_req_addr;
  logic [7:0]  rd_req_len, wr_req_len;
  logic        rd_req_valid, wr_req_valid, rd_ready, wr_valid, wr_last;
  logic        rd_req_ready = 1'b1, wr_req_ready = 1'b1;
  logic [31:0] rd_rdata = '0;
  logic        rd_valid = 1'b0, rd_last = 1'b0;
  logic [31:0] wr_data, fifo_wdata;
  logic        fifo_wen, fifo_rden;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_is_empty = 1'b1, fifo_full_m = 1'b0, force_full = 1'b0;
  logic        fifo_is_full, wr_ready;
  logic        wr_ready_q = 1'b1, rand_wr = 1'b0;

  assign fifo_is_full = fifo_full_m | force_full;
  assign wr_ready     = wr_ready_q;

  always #5 clk = ~clk;

  dma_ring_engine #(.DATA_WIDTH(32), .BURST_BEATS(8), .RING_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .src_base(src_base), .dest_base(dest_base), .tail_ptr(tail_ptr), .head_ptr(head_ptr),
    .dma_size(dma_size), .ctrl_stat(ctrl_stat), .intr(intr),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_rdata(rd_rdata), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_ready(rd_ready), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_rden(fifo_rden),
    .fifo_rdata(fifo_rdata), .fifo_is_empty(fifo_is_empty), .fifo_is_full(fifo_is_full)
  );

  logic [39:0] exp_rq[$];
  logic [39:0] exp_wq[$];
  logic [32:0] exp_beat[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string act, input string exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  logic [39:0] m_req;
  logic [32:0] m_beat;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_req_valid && rd_req_ready) begin
        if (exp_rq.size() == 0) flag("rd_req_extra", "handshake", "none");
        else begin
          m_req = exp_rq.pop_front();
          chk("rd_req_addr", rd_req_addr, m_req[39:8]);
          chk("rd_req_len", {24'h0, rd_req_len}, {24'h0, m_req[7:0]});
        end
      end
      if (wr_req_valid && wr_req_ready) begin
        if (exp_wq.size() == 0) flag("wr_req_extra", "handshake", "none");
        else begin
          m_req = exp_wq.pop_front();
          chk("wr_req_addr", wr_req_addr, m_req[39:8]);
          chk("wr_req_len", {24'h0, wr_req_len}, {24'h0, m_req[7:0]});
        end
      end
      if (wr_valid && wr_ready) begin
        if (exp_beat.size() == 0) flag("wr_beat_extra", "beat", "none");
        else begin
          m_beat = exp_beat.pop_front();
          chk("wr_data", wr_data, m_beat[31:0]);
          chk("wr_last", {31'h0, wr_last}, {31'h0, m_beat[32]});
        end
      end
    end
  end

  // Memory read responder and show-ahead FIFO model; inputs change only 1ns after the edge.
  logic [31:0] fq[$];
  logic [31:0] pend_addr[$];
  logic [7:0]  pend_len[$];
  logic [31:0] cur_addr = '0;
  logic [7:0]  cur_len = '0, rd_k = '0;
  logic        rd_active = 1'b0;
  logic        s_rst, s_rdreq, s_rdbeat, s_wen, s_ren;
  logic [31:0] s_addr, s_wdata;
  logic [7:0]  s_len;
  always begin
    @(negedge clk);
    s_rst    = !rst_n;
    s_rdreq  = rd_req_valid && rd_req_ready;
    s_addr   = rd_req_addr;
    s_len    = rd_req_len;
    s_rdbeat = rd_valid && rd_ready;
    s_wen    = fifo_wen;
    s_wdata  = fifo_wdata;
    s_ren    = fifo_rden;
    @(posedge clk);
    #1;
    if (s_rst) begin
      fq.delete();
      pend_addr.delete();
      pend_len.delete();
      rd_active = 1'b0;
      rd_k = '0;
    end else begin
      if (s_ren && fq.size() != 0) void'(fq.pop_front());
      if (s_wen) fq.push_back(s_wdata);
      if (s_rdreq) begin
        pend_addr.push_back(s_addr);
        pend_len.push_back(s_len);
      end
      if (s_rdbeat) begin
        if (rd_k == cur_len) rd_active = 1'b0;
        else rd_k = rd_k + 8'd1;
      end
      if (!rd_active && pend_addr.size() != 0) begin
        cur_addr = pend_addr.pop_front();
        cur_len  = pend_len.pop_front();
        rd_k = '0;
        rd_active = 1'b1;
      end
    end
    rd_valid      = rd_active;
    rd_rdata      = cur_addr + {22'h0, rd_k, 2'b00};
    rd_last       = rd_active && (rd_k == cur_len);
    fifo_is_empty = (fq.size() == 0);
    fifo_rdata    = fifo_is_empty ? 32'h0 : fq[0];
    fifo_full_m   = (fq.size() >= 16);
    wr_ready_q    = rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic push_burst(input logic [31:0] rd_a, input logic [31:0] wr_a, input logic [7:0] len);
    exp_rq.push_back({rd_a, len});
    exp_wq.push_back({wr_a, len});
    for (int k = 0; k <= int'(len); k++)
      exp_beat.push_back({(k == int'(len)), rd_a + 32'(k * 4)});
  endtask

  task automatic wr_raw(input logic [5:0] en, input logic [31:0] d);
    reg_wr_en = en;
    reg_wr_data = d;
    @(posedge clk);
    #1;
    reg_wr_en = '0;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] d);
    wr_raw(6'b1 << idx, d);
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] d, input logic [31:0] t,
                     input logic [31:0] h, input logic [31:0] sz, input logic [31:0] c);
    wr_reg(5, 32'h0);
    wr_reg(0, s);
    wr_reg(1, d);
    wr_reg(2, t);
    wr_reg(3, h);
    wr_reg(4, sz);
    wr_reg(5, c);
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ctrl_stat[31]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag({name, "_done"}, "no DONE in 400 cycles", "DONE");
    @(posedge clk);
    #1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_rq_left"}, exp_rq.size(), 0);
    chk({name, "_wq_left"}, exp_wq.size(), 0);
    chk({name, "_beats_left"}, exp_beat.size(), 0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_src"}, src_base, 0);
    chk({name, "_dest"}, dest_base, 0);
    chk({name, "_tail"}, tail_ptr, 0);
    chk({name, "_head"}, head_ptr, 0);
    chk({name, "_size"}, dma_size, 0);
    chk({name, "_ctrl"}, ctrl_stat, 0);
    chk({name, "_rd_req_addr"}, rd_req_addr, 0);
    chk({name, "_valids"}, {24'h0, rd_req_valid, wr_req_valid, rd_ready, wr_valid,
                            wr_last, fifo_wen, fifo_rden, intr}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_zero("reset");

    wr_raw(6'b000011, 32'hDEAD_BEEF);
    chk("twohot_src", src_base, 0);
    chk("twohot_dest", dest_base, 0);

    // Basic transfer
    push_burst(32'h1000, 32'h8000, 8'd7);
    push_burst(32'h1020, 32'h8020, 8'd7);
    cfg(32'h1000, 32'h8000, 32'h0, 32'h40, 32'h40, 32'h3);
    wait_done("basic");
    chk("basic_tail", tail_ptr, 32'h40);
    chk("basic_ctrl", ctrl_stat, 32'h8000_0003);
    chk("basic_intr", {31'h0, intr}, 1);

    // Partial last burst
    push_burst(32'h2000, 32'h9000, 8'd7);
    push_burst(32'h2020, 32'h9020, 8'd2);
    cfg(32'h2000, 32'h9000, 32'h0, 32'h2C, 32'h2C, 32'h3);
    wait_done("partial");
    chk("partial_tail", tail_ptr, 32'h2C);

    // Wrap-around at 256-byte ring
    push_burst(32'h30E0, 32'hA0E0, 8'd7);
    push_burst(32'h3000, 32'hA000, 8'd7);
    cfg(32'h3000, 32'hA000, 32'hE0, 32'h20, 32'h40, 32'h3);
    wait_done("wrap");
    chk("wrap_tail", tail_ptr, 32'h20);

    // FIFO full for 5 cycles in RDAT
    push_burst(32'h4000, 32'hB000, 8'd7);
    cfg(32'h4000, 32'hB000, 32'h0, 32'h20, 32'h20, 32'h3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_req_valid && rd_req_ready) break;
    end
    @(posedge clk);
    #1;
    force_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_rd_ready", {31'h0, rd_ready}, 0);
      chk("full_fifo_wen", {31'h0, fifo_wen}, 0);
    end
    @(posedge clk);
    #1;
    force_full = 1'b0;
    wait_done("full");
    chk("full_tail", tail_ptr, 32'h20);

    // Random wr_ready
    rand_wr = 1'b1;
    push_burst(32'h5000, 32'hC000, 8'd7);
    push_burst(32'h5020, 32'hC020, 8'd7);
    cfg(32'h5000, 32'hC000, 32'h0, 32'h40, 32'h40, 32'h3);
    wait_done("randwr");
    rand_wr = 1'b0;
    chk("randwr_ctrl_noerr", ctrl_stat, 32'h8000_0003);

    // dma_size rewritten mid-run
    push_burst(32'h6000, 32'hD000, 8'd7);
    push_burst(32'h6020, 32'hD020, 8'd7);
    cfg(32'h6000, 32'hD000, 32'h0, 32'h40, 32'h40, 32'h3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_req_valid && rd_req_ready) break;
    end
    @(posedge clk);
    #1;
    wr_reg(4, 32'h100);
    wait_done("midsize");
    chk("midsize_tail", tail_ptr, 32'h40);
    chk("midsize_size", dma_size, 32'h100);

    // IE=0 then clear DONE
    push_burst(32'h7000, 32'hE000, 8'd7);
    cfg(32'h7000, 32'hE000, 32'h0, 32'h20, 32'h20, 32'h1);
    wait_done("noie");
    chk("noie_ctrl", ctrl_stat, 32'h8000_0001);
    chk("noie_intr", {31'h0, intr}, 0);
    wr_reg(5, 32'h1);
    chk("noie_clr_ctrl", ctrl_stat, 32'h1);
    chk("noie_clr_intr", {31'h0, intr}, 0);

    // Reset during WDAT
    push_burst(32'h1000, 32'h8000, 8'd7);
    push_burst(32'h1020, 32'h8020, 8'd7);
    cfg(32'h1000, 32'h8000, 32'h0, 32'h40, 32'h40, 32'h3);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (wr_valid && wr_ready) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) flag("rst_wait_wdat", "no write beat", "write beat");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst_mid");
    exp_rq.delete();
    exp_wq.delete();
    exp_beat.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_idle_rd_req_valid", {31'h0, rd_req_valid}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_ring_engine.md
# dma_ring_engine

Parametrised successor to the single-channel DMA engine core. It copies sub-buffers from a source ring to a destination ring through an external show-ahead FIFO, using the memory read/write request/data handshakes. Compared with the fixed 32-bit, 8-beat engine, it adds configurable data width and burst length, and a short final burst when `dma_size` is not a whole number of bursts. It also adds pointer wrap-around at a power-of-two ring size, latched working copies of the configuration registers, maskable completion interrupts and a sticky FIFO error flag.

## Interface
- `DATA_WIDTH`, default 32: beat width; must be 32 or 64. Beat bytes `BB = DATA_WIDTH/8`.
- `BURST_BEATS`, default 8: maximum beats per burst; power of two, 2..16. Burst bytes `BSZ = BURST_BEATS*BB`.
- `RING_BYTES`, default 65536: ring size in bytes; power of two and a multiple of `BSZ`.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `reg_wr_data` in 32: CPU register write data.
- `reg_wr_en` in 6: one-hot register write select. Bit 0 src, 1 dest, 2 tail, 3 head, 4 size, 5 ctrl. Any other value writes nothing.
- `src_base`, `dest_base`, `tail_ptr`, `head_ptr`, `dma_size`, `ctrl_stat` out 32 each: register readback.
- `intr` out 1: `ctrl_stat[31] & ctrl_stat[1]`.
- Read request: `rd_req_addr` out 32, `rd_req_len` out 8 (beats-1), `rd_req_valid` out 1, `rd_req_ready` in 1.
- Read data: `rd_rdata` in `DATA_WIDTH`, `rd_valid` in 1, `rd_last` in 1, `rd_ready` out 1.
- Write request: `wr_req_addr` out 32, `wr_req_len` out 8, `wr_req_valid` out 1, `wr_req_ready` in 1.
- Write data: `wr_data` out `DATA_WIDTH`, `wr_valid` out 1, `wr_last` out 1, `wr_ready` in 1.
- FIFO: `fifo_wdata` out `DATA_WIDTH`, `fifo_wen` out 1, `fifo_rden` out 1, `fifo_rdata` in `DATA_WIDTH`, `fifo_is_empty` in 1, `fifo_is_full` in 1.
  - The FIFO is show-ahead: `fifo_rdata` is valid whenever `fifo_is_empty` is 0.

## Operation
- `ctrl_stat` bits:
  - `[0]` EN.
  - `[1]` IE (interrupt enable).
  - `[30]` ERR, sticky.
  - `[31]` DONE, sticky.
  - Other bits are plain storage.
- Start condition, sampled in IDLE: EN=1, `head_ptr != tail_ptr`, and `dma_size[31:log2(BB)] != 0`.
- On start, the engine latches working copies and clears the byte offset to 0:
  - `src_base` → `s_l`, `dest_base` → `d_l`.
  - `tail_ptr` → `t_l`.
  - beats = `dma_size >> log2(BB)` → `rem`. Size bits below `BB` are ignored.
- Register writes while busy update the visible registers only. The running sub-buffer keeps using the latched values.
- FSM states are IDLE, RREQ, RDAT, WREQ, WDAT; reset enters IDLE.
  - IDLE → RREQ on the start condition.
  - RREQ → RDAT on `rd_req_valid & rd_req_ready`.
  - RDAT → WREQ on the accepted beat with `rd_last` = 1.
  - WREQ → WDAT on `wr_req_valid & wr_req_ready`.
  - WDAT → RREQ after the final write beat if `rem` is still nonzero; otherwise WDAT → IDLE.
- Burst length: `n = min(BURST_BEATS, rem)`. `rd_req_len = wr_req_len = n-1`, computed in RREQ and held until WDAT ends.
- Addresses:
  - `rd_req_addr = s_l + ((t_l + off) mod RING_BYTES)`.
  - `wr_req_addr = d_l + ((t_l + off) mod RING_BYTES)`.
  - After each burst, `off += n*BB` and `rem -= n`.
- RDAT:
  - `rd_ready = ~fifo_is_full`.
  - `fifo_wen = rd_valid & rd_ready`.
  - `fifo_wdata = rd_rdata`.
- WDAT:
  - `wr_valid = ~fifo_is_empty`.
  - `wr_data = fifo_rdata`.
  - `fifo_rden = wr_valid & wr_ready`.
  - A beat counter counts up to `n-1`; `wr_last = wr_valid & (cnt == n-1)`.
- Completion happens on the cycle of the final beat of the last burst:
  - `tail_ptr <= (t_l + rem0*BB) mod RING_BYTES`, where `rem0` is `rem` at start.
  - `ctrl_stat[31]` is set.
  - If the start condition still holds, the next sub-buffer starts.
- ERR is set when `fifo_wen & fifo_is_full` or `fifo_rden & fifo_is_empty`. It is cleared only by a CPU write.
- Software constraint, not checked: `tail_ptr` is `BSZ`-aligned. The modulo math therefore never splits a burst.

## Timing
- Reset (`rst_n`=0 at an edge) clears everything the following cycle:
  - All registers, the working copies and the beat counter are 0.
  - `state` = IDLE.
  - `rd_req_valid`, `wr_req_valid`, `rd_ready`, `wr_valid`, `wr_last`, `fifo_wen`, `fifo_rden` and `intr` are 0.
- Reset mid-transfer aborts immediately: no drain, no tail update.
- A register write is visible on the outputs the cycle after the write edge.
- Start is sampled one cycle after the write; `rd_req_valid` is high from the next cycle.
- `rd_req_valid` and `wr_req_valid` are 1 exactly while in RREQ and WREQ respectively. Address and length stay stable until accepted.
- Throughput is 1 beat per cycle in RDAT and WDAT when not stalled.
- `rd_ready` is 0 outside RDAT. Read beats arriving outside RDAT are not consumed.
- A CPU write to `tail_ptr` in the same cycle as a hardware update: the CPU value wins.
- A CPU write to `ctrl_stat` in the same cycle as DONE/ERR set: the result is `reg_wr_data` OR the set bits.
- DONE → `intr` has 1 cycle of latency after the final write beat edge.

## Test plan
- Basic transfer, defaults, `src_base`=0x1000, `dest_base`=0x8000, `tail_ptr`=0, `head_ptr`=0x40, `dma_size`=0x40, `ctrl_stat`=3:
  - Expect 2 bursts with len 7.
  - Read addresses 0x1000 and 0x1020; write addresses 0x8000 and 0x8020.
  - Then `tail_ptr`=0x40, `ctrl_stat`=0x80000003, `intr`=1.
- Partial last burst, `dma_size`=0x2C:
  - Expect bursts of len 7 then len 2.
  - `wr_last` on the 3rd beat of the 2nd burst; `tail_ptr`=0x2C.
- Wrap-around, `RING_BYTES`=256, `tail_ptr`=0xE0, `dma_size`=0x40:
  - Second read address is `src_base`+0x00.
  - Final `tail_ptr`=0x20.
- Backpressure:
  - Hold `fifo_is_full`=1 for 5 cycles in RDAT → `rd_ready`=0 and no `fifo_wen`.
  - Toggle `wr_ready` randomly → data order is preserved and ERR stays 0.
- Mid-run effects:
  - Write `dma_size`=0x100 during burst 1 → the current sub-buffer still finishes after 0x40.
  - Assert `rst_n`=0 during WDAT → all outputs are 0 the next cycle and `state` is IDLE.
- IE=0 with DONE set → `intr`=0. A CPU write of `ctrl_stat`=1 then clears DONE.
